fwrisc_regfile_mp: RTL
======================

// Module: fwrisc_regfile_mp
// PURPOSE
//  Parametrised multi-read-port GPR file plus machine-mode CSR block for fwrisc cores.
//  - Generalises XLEN, GPR count (RV32I/RV32E), number of read ports and counter width.
//  - Adds optional write-to-read bypass.
//  - Sits between decode (read addresses), writeback (rd port) and exception logic (trap/tret).
// PARAMETERS
//  XLEN        32  data width of GPRs and CSR read data
//  NUM_GPR     32  implemented GPRs, 16 (RV32E) or 32; index 0 hardwired to zero
//  N_RD_PORTS  2   read ports, 1..4; every port can address GPRs and CSRs
//  COUNTER_W   64  mcycle/minstret width, 32 or 64
//  ENABLE_DEP  1   1: dep_lo/dep_hi registers implemented; 0: outputs tied to 0
// PORTS
//  clock           in   1              core clock, all state on posedge
//  reset           in   1              asynchronous, active-high
//  instr_complete  in   1              retire strobe, increments minstret
//  trap            in   1              exception/interrupt entry
//  tret            in   1              mret
//  irq             in   1              external interrupt level, reflected in mip[11]
//  raddr           in   6*N_RD_PORTS   port p address = raddr[6p+:6]; 0..31 GPR, 32..63 CSR index
//  rdata           out  XLEN*N_RD_PORTS port p data = rdata[XLEN*p+:XLEN]
//  rd_waddr        in   6              write address
//  rd_wdata        in   XLEN           write data
//  rd_wen          in   1              write enable
//  soft_reset_req  out  1              combinational: rd_wen && rd_waddr==CSR_SOFT_RESET
//  dep_lo, dep_hi  out  XLEN           DEP bounds
//  mtvec           out  XLEN           trap vector
//  meie            out  1              mie.MEIE
//  mie             out  1              mstatus.MIE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All GPRs, counters, dep_*, mtvec and rdata clear to 0.
//   - meie=1, mie=1, mpie=0.
//  Reads: registered, 1-cycle latency, independent per port.
//   - Address 0, or GPR index >= NUM_GPR, returns 0.
//   - CSR indices use fwrisc_csr_addr.svh:
//     - MHARTID=0; MSTATUS={mpie@7, mie@3}; MIP={irq@11}; MTVEC.
//     - MCYCLE/MINSTRET = low XLEN bits.
//     - MCYCLEH/MINSTRETH = upper bits, or 0 when COUNTER_W=32.
//     - DEP_LO/DEP_HI read back their register.
//     - Other CSR indices read the 32..63 backing array.
//  Writes: rd_wen commits on the next posedge.
//   - Index 0 and GPR indices >= NUM_GPR are dropped.
//   - CSR indices update the named CSR, or the backing array otherwise.
//  Read-during-write to the same address (no bypass): the port returns the OLD value.
//  Counters:
//   - mcycle +1 every cycle; minstret +1 when instr_complete.
//   - Both wrap at 2^COUNTER_W.
//   - A write to a half replaces that half this cycle and suppresses that counter's increment.
//  Interrupt state:
//   - trap: mpie<=mie, mie<=0.
//   - tret: mie<=mpie, mpie<=1 (not 0).
//   - trap && tret in the same cycle: trap wins, tret ignored.
//   - trap/tret take priority over a same-cycle MSTATUS write (write dropped).
//   - MIE write: meie<=wdata[11].
//  DEP:
//   - A write to dep_lo/dep_hi is ignored once that register's bit1 (enable) is 1.
//   - Lock holds until reset.
//   - With ENABLE_DEP=0: writes dropped, reads return 0.
//  mtvec: writes bits [XLEN-1:2]; bits [1:0] forced 0 (direct mode only).
//  Reset mid-operation clears all state immediately; pending write lost.
// CONFIGURATION
//  FWRISC_REGFILE_BYPASS_EN:
//   - Defined: a read of address A in the cycle rd_wen writes A (A!=0, implemented)
//     returns rd_wdata next cycle. Applies to GPRs and writable CSRs.
//   - Counters: a bypassed counter read returns rd_wdata for the written half;
//     the other half shows the pre-increment value.
//   - Undefined: old value returned, as above; no bypass muxes synthesised.
// TESTING
//  1. Reset, read x0..x31 on all ports -> all 0; meie=1, mie=1, MSTATUS reads 0x08.
//  2. Write x5=0xDEADBEEF, next cycle read x5 on ports 0 and 1 -> both 0xDEADBEEF;
//     write x0=1 -> x0 reads 0. With NUM_GPR=16, write x20=7 -> x20 reads 0.
//  3. Write x7=0x11, then write x7=0x22 while reading x7 in the same cycle:
//     without bypass -> 0x11, with FWRISC_REGFILE_BYPASS_EN -> 0x22.
//  4. Write MCYCLE=0xFFFFFFFF, MCYCLEH=0 -> two cycles later MCYCLEH=1 (COUNTER_W=64);
//     with COUNTER_W=32 MCYCLEH=0 and MCYCLE wraps to 0.
//  5. mie=1: trap -> MSTATUS 0x80, mie=0; tret -> MSTATUS 0x88;
//     trap&&tret in the same cycle from 0x08 -> 0x80.
//  6. Write DEP_LO=0x1002 -> reads 0x1002; write DEP_LO=0x0 -> still 0x1002;
//     assert reset mid-sequence -> 0 and writable again.

Source files
------------

// File: rtl/fwrisc_regfile_mp.sv
// Multi-read-port GPR file and machine-mode CSR block for fwrisc cores.
// Optional write-to-read bypass is enabled by defining FWRISC_REGFILE_BYPASS_EN.
module fwrisc_regfile_mp #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_GPR    = 32,
    parameter int unsigned N_RD_PORTS = 2,
    parameter int unsigned COUNTER_W  = 64,
    parameter int unsigned ENABLE_DEP = 1
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         instr_complete_i,
    input  logic                         trap_i,
    input  logic                         tret_i,
    input  logic                         irq_i,
    input  logic [6*N_RD_PORTS-1:0]      raddr_i,
    output logic [XLEN*N_RD_PORTS-1:0]   rdata_o,
    input  logic [5:0]                   rd_waddr_i,
    input  logic [XLEN-1:0]              rd_wdata_i,
    input  logic                         rd_wen_i,
    output logic                         soft_reset_req_o,
    output logic [XLEN-1:0]              dep_lo_o,
    output logic [XLEN-1:0]              dep_hi_o,
    output logic [XLEN-1:0]              mtvec_o,
    output logic                         meie_o,
    output logic                         mie_o
);

    localparam logic [5:0] CsrMstatus   = 6'd32;
    localparam logic [5:0] CsrMie       = 6'd33;
    localparam logic [5:0] CsrMtvec     = 6'd34;
    localparam logic [5:0] CsrMip       = 6'd39;
    localparam logic [5:0] CsrMcycle    = 6'd40;
    localparam logic [5:0] CsrMcycleh   = 6'd41;
    localparam logic [5:0] CsrMinstret  = 6'd42;
    localparam logic [5:0] CsrMinstreth = 6'd43;
    localparam logic [5:0] CsrMhartid   = 6'd44;
    localparam logic [5:0] CsrDepLo     = 6'd45;
    localparam logic [5:0] CsrDepHi     = 6'd46;
    localparam logic [5:0] CsrSoftReset = 6'd47;

    localparam logic [COUNTER_W-1:0] LoMask = COUNTER_W'({XLEN{1'b1}});
    localparam logic [COUNTER_W-1:0] CntOne = COUNTER_W'(1);

    logic [XLEN-1:0]      gpr_q  [32];
    logic [XLEN-1:0]      bank_q [32];
    logic [COUNTER_W-1:0] mcycle_q, mcycle_d;
    logic [COUNTER_W-1:0] minstret_q, minstret_d;
    logic [XLEN-1:0]      dep_lo_q, dep_hi_q, mtvec_q;
    logic                 meie_q, meie_d, mie_q, mie_d, mpie_q, mpie_d;

    logic wr_ok, wr_bank;
    logic wr_gpr, wr_mstatus, wr_mie, wr_mtvec;
    logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth, wr_dep_lo, wr_dep_hi;

    // wr_ok: the write actually lands (address implemented, writable, not locked)
    always_comb begin
        wr_ok   = 1'b0;
        wr_bank = 1'b0;
        if (rd_wen_i) begin
            if (!rd_waddr_i[5]) begin
                wr_ok = (rd_waddr_i != 6'd0) && (32'(rd_waddr_i) < NUM_GPR);
            end else begin
                case (rd_waddr_i)
                    CsrMhartid, CsrMip:        wr_ok = 1'b0;
                    CsrMstatus:                wr_ok = !(trap_i || tret_i);
                    CsrMie, CsrMtvec:          wr_ok = 1'b1;
                    CsrMcycle, CsrMinstret:    wr_ok = 1'b1;
                    CsrMcycleh, CsrMinstreth:  wr_ok = COUNTER_W > XLEN;
                    CsrDepLo:                  wr_ok = (ENABLE_DEP != 0) && !dep_lo_q[1];
                    CsrDepHi:                  wr_ok = (ENABLE_DEP != 0) && !dep_hi_q[1];
                    default: begin
                        wr_ok   = 1'b1;
                        wr_bank = 1'b1;
                    end
                endcase
            end
        end
    end

    assign wr_gpr       = wr_ok && !rd_waddr_i[5];
    assign wr_mstatus   = wr_ok && (rd_waddr_i == CsrMstatus);
    assign wr_mie       = wr_ok && (rd_waddr_i == CsrMie);
    assign wr_mtvec     = wr_ok && (rd_waddr_i == CsrMtvec);
    assign wr_mcycle    = wr_ok && (rd_waddr_i == CsrMcycle);
    assign wr_mcycleh   = wr_ok && (rd_waddr_i == CsrMcycleh);
    assign wr_minstret  = wr_ok && (rd_waddr_i == CsrMinstret);
    assign wr_minstreth = wr_ok && (rd_waddr_i == CsrMinstreth);
    assign wr_dep_lo    = wr_ok && (rd_waddr_i == CsrDepLo);
    assign wr_dep_hi    = wr_ok && (rd_waddr_i == CsrDepHi);

    // A half write replaces that half and suppresses this cycle's increment
    always_comb begin
        mcycle_d = mcycle_q + CntOne;
        if (wr_mcycle) begin
            mcycle_d = (mcycle_q & ~LoMask) | COUNTER_W'(rd_wdata_i);
        end else if (wr_mcycleh) begin
            mcycle_d = (mcycle_q & LoMask) | (COUNTER_W'(rd_wdata_i) << XLEN);
        end
        minstret_d = instr_complete_i ? minstret_q + CntOne : minstret_q;
        if (wr_minstret) begin
            minstret_d = (minstret_q & ~LoMask) | COUNTER_W'(rd_wdata_i);
        end else if (wr_minstreth) begin
            minstret_d = (minstret_q & LoMask) | (COUNTER_W'(rd_wdata_i) << XLEN);
        end
    end

    always_comb begin
        mie_d  = mie_q;
        mpie_d = mpie_q;
        meie_d = meie_q;
        if (trap_i) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (tret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_mstatus) begin
            mie_d  = rd_wdata_i[3];
            mpie_d = rd_wdata_i[7];
        end
        if (wr_mie) begin
            meie_d = rd_wdata_i[11];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i]  <= '0;
                bank_q[i] <= '0;
            end
            mcycle_q   <= '0;
            minstret_q <= '0;
            dep_lo_q   <= '0;
            dep_hi_q   <= '0;
            mtvec_q    <= '0;
            meie_q     <= 1'b1;
            mie_q      <= 1'b1;
            mpie_q     <= 1'b0;
        end else begin
            if (wr_gpr)    gpr_q[rd_waddr_i[4:0]]  <= rd_wdata_i;
            if (wr_bank)   bank_q[rd_waddr_i[4:0]] <= rd_wdata_i;
            if (wr_dep_lo) dep_lo_q <= rd_wdata_i;
            if (wr_dep_hi) dep_hi_q <= rd_wdata_i;
            if (wr_mtvec)  mtvec_q  <= {rd_wdata_i[XLEN-1:2], 2'b00};
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            meie_q     <= meie_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
        end
    end

    for (genvar p = 0; p < N_RD_PORTS; p++) begin : g_port
        logic [5:0]      addr;
        logic [XLEN-1:0] rdata_d, rdata_q;

        assign addr = raddr_i[6*p+:6];

        always_comb begin
            rdata_d = '0;
            if (!addr[5]) begin
                if ((addr != 6'd0) && (32'(addr) < NUM_GPR)) begin
                    rdata_d = gpr_q[addr[4:0]];
                end
            end else begin
                case (addr)
                    CsrMhartid:   rdata_d = '0;
                    CsrMstatus:   rdata_d = (XLEN'(mpie_q) << 7) | (XLEN'(mie_q) << 3);
                    CsrMie:       rdata_d = XLEN'(meie_q) << 11;
                    CsrMip:       rdata_d = XLEN'(irq_i) << 11;
                    CsrMtvec:     rdata_d = mtvec_q;
                    CsrMcycle:    rdata_d = XLEN'(mcycle_q);
                    CsrMcycleh:   rdata_d = XLEN'(mcycle_q >> XLEN);
                    CsrMinstret:  rdata_d = XLEN'(minstret_q);
                    CsrMinstreth: rdata_d = XLEN'(minstret_q >> XLEN);
                    CsrDepLo:     rdata_d = dep_lo_q;
                    CsrDepHi:     rdata_d = dep_hi_q;
                    default:      rdata_d = bank_q[addr[4:0]];
                endcase
            end
`ifdef FWRISC_REGFILE_BYPASS_EN
            if (wr_ok && (rd_waddr_i == addr)) begin
                rdata_d = rd_wdata_i;
            end
`endif
        end

        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata_o[XLEN*p+:XLEN] = rdata_q;
    end

    assign soft_reset_req_o = rd_wen_i && (rd_waddr_i == CsrSoftReset);
    assign dep_lo_o         = dep_lo_q;
    assign dep_hi_o         = dep_hi_q;
    assign mtvec_o          = mtvec_q;
    assign meie_o           = meie_q;
    assign mie_o            = mie_q;

endmodule
